uart_tx: RTL and testbench

// - 8N1 UART transmitter; the transmit-side counterpart of UART_RX on the same x16_BAUD tick clock.
// - Serialises one byte per handshake: start bit, 8 data bits LSB first, stop bit(s); each bit held P_OVERSAMPLE clocks.
// - Idle line is high. serial_out connects directly to a UART_RX serial_in for loopback.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 45 ++++
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM states,
// default frame geometry and line levels.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int   LP_OVERSAMPLE = 16;
   localparam int   LP_DATA_BITS  = 8;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter shared by the UART transmitter and receiver.
// Counts 0..P_OVERSAMPLE-1 while not cleared; bit_end marks the last tick.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter  int P_OVERSAMPLE = LP_OVERSAMPLE,
   localparam int LP_TICK_W    = $clog2(P_OVERSAMPLE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   output logic [LP_TICK_W-1:0] tick_next,
   output logic                 bit_end
);

   localparam logic [LP_TICK_W-1:0] LP_TICK_LAST = LP_TICK_W'(P_OVERSAMPLE - 1);

   logic [LP_TICK_W-1:0] tick_q;
   logic [LP_TICK_W-1:0] tick_d;

   // Next tick: wrap at the end of a bit, hold at zero while cleared.
   always_comb begin
      tick_d = tick_q;
      if (clear) begin
         tick_d = {LP_TICK_W{1'b0}};
      end else if (tick_q == LP_TICK_LAST) begin
         tick_d = {LP_TICK_W{1'b0}};
      end else begin
         tick_d = tick_q + LP_TICK_W'(1);
      end
   end

   // Tick register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q <= {LP_TICK_W{1'b0}};
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick_next = tick_d;
   assign bit_end   = (tick_q == LP_TICK_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Optional parity bit enabled with macro UART_TX_PARITY_EN.
module uart_tx
   import uart_pkg::*;
#(
   parameter int P_OVERSAMPLE = LP_OVERSAMPLE,
   parameter int P_DATA_BITS  = LP_DATA_BITS,
   parameter int P_STOP_BITS  = 1,
   parameter bit P_ODD_PARITY = 1'b0
) (
   input  logic                   x16_BAUD,
   input  logic                   reset,
   input  logic [P_DATA_BITS-1:0] Di,
   input  logic                   valid,
   output logic                   ready,
   output logic                   serial_out,
   output logic                   done
);

   localparam int LP_TICK_W = $clog2(P_OVERSAMPLE);
   localparam int LP_BIT_W  = $clog2(P_DATA_BITS);

   localparam logic [LP_TICK_W-1:0] LP_TICK_LAST = LP_TICK_W'(P_OVERSAMPLE - 1);
   localparam logic [LP_BIT_W-1:0]  LP_BIT_LAST  = LP_BIT_W'(P_DATA_BITS - 1);
   localparam logic [1:0]           LP_STOP_LAST = 2'(P_STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   localparam uart_state_e LP_AFTER_DATA = ST_PARITY;
`else
   localparam uart_state_e LP_AFTER_DATA = ST_STOP;
`endif

   function automatic logic parity_bit(input logic [P_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   uart_state_e            state_q, state_d;
   logic [P_DATA_BITS-1:0] shift_q, shift_d;
   logic [P_DATA_BITS-1:0] data_q, data_d;
   logic [LP_BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [1:0]             stop_cnt_q, stop_cnt_d;
   logic                   serial_out_q, serial_out_d;
   logic                   ready_q, ready_d;
   logic                   done_q, done_d;

   logic [LP_TICK_W-1:0]   tick_next_s;
   logic                   bit_end_s;
   logic                   tick_clr_s;
   logic                   accept_s;

   assign accept_s   = valid && ready_q;
   assign tick_clr_s = (state_q == ST_IDLE);

   uart_bit_timer #(
      .P_OVERSAMPLE (P_OVERSAMPLE)
   ) u_bit_timer (
      .clk       (x16_BAUD),
      .rst       (reset),
      .clear     (tick_clr_s),
      .tick_next (tick_next_s),
      .bit_end   (bit_end_s)
   );

   // State register.
   always_ff @(posedge x16_BAUD or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; an accept on the final stop clock re-enters START directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_START;
            else          state_d = ST_IDLE;
         end
         ST_START: begin
            if (bit_end_s) state_d = ST_DATA;
            else           state_d = ST_START;
         end
         ST_DATA: begin
            if (bit_end_s && (bit_cnt_q == LP_BIT_LAST)) state_d = LP_AFTER_DATA;
            else                                         state_d = ST_DATA;
         end
         ST_PARITY: begin
            if (bit_end_s) state_d = ST_STOP;
            else           state_d = ST_PARITY;
         end
         ST_STOP: begin
            if (bit_end_s && (stop_cnt_q == LP_STOP_LAST)) begin
               if (accept_s) state_d = ST_START;
               else          state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift register, latched byte and bit/stop counters.
   always_comb begin
      shift_d    = shift_q;
      data_d     = data_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      if (accept_s) begin
         shift_d    = Di;
         data_d     = Di;
         bit_cnt_d  = {LP_BIT_W{1'b0}};
         stop_cnt_d = 2'd0;
      end else begin
         case (state_q)
            ST_DATA: begin
               if (bit_end_s) begin
                  shift_d = {1'b0, shift_q[P_DATA_BITS-1:1]};
                  if (bit_cnt_q == LP_BIT_LAST) bit_cnt_d = {LP_BIT_W{1'b0}};
                  else                          bit_cnt_d = bit_cnt_q + LP_BIT_W'(1);
               end else begin
                  shift_d = shift_q;
               end
            end
            ST_STOP: begin
               if (bit_end_s) begin
                  if (stop_cnt_q == LP_STOP_LAST) stop_cnt_d = 2'd0;
                  else                            stop_cnt_d = stop_cnt_q + 2'd1;
               end else begin
                  stop_cnt_d = stop_cnt_q;
               end
            end
            default: begin
               shift_d = shift_q;
            end
         endcase
      end
   end

   // Outputs are computed from next-cycle state so they can be registered.
   always_comb begin
      done_d  = (state_d == ST_STOP) && (tick_next_s == LP_TICK_LAST) &&
                (stop_cnt_d == LP_STOP_LAST);
      ready_d = (state_d == ST_IDLE) || done_d;
      case (state_d)
         ST_START:  serial_out_d = LINE_START;
         ST_DATA:   serial_out_d = shift_d[0];
         ST_PARITY: serial_out_d = parity_bit(data_q, P_ODD_PARITY);
         ST_STOP:   serial_out_d = LINE_IDLE;
         ST_IDLE:   serial_out_d = LINE_IDLE;
         default:   serial_out_d = LINE_IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge x16_BAUD or posedge reset) begin
      if (reset) begin
         shift_q      <= {P_DATA_BITS{1'b0}};
         data_q       <= {P_DATA_BITS{1'b0}};
         bit_cnt_q    <= {LP_BIT_W{1'b0}};
         stop_cnt_q   <= 2'd0;
         serial_out_q <= LINE_IDLE;
         ready_q      <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         data_q       <= data_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         serial_out_q <= serial_out_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
      end
   end

   assign serial_out = serial_out_q;
   assign ready      = ready_q;
   assign done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (default 8N1, or 8E1/8O1 with
// UART_TX_PARITY_EN defined).
module tb_uart_tx;

   localparam int OS     = 16;
   localparam bit TB_ODD = 1'b0;
   localparam int PB     = int'(TB_ODD);
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * OS;

   typedef int lv_t[11];

   // Line levels per bit time, in transmission order (start, d0..d7, [parity], stop).
`ifdef UART_TX_PARITY_EN
   localparam lv_t LV_A6 = '{0, 0, 1, 1, 0, 0, 1, 0, 1, PB, 1};
   localparam lv_t LV_3C = '{0, 0, 0, 1, 1, 1, 1, 0, 0, PB, 1};
   localparam lv_t LV_00 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, PB, 1};
   localparam lv_t LV_FF = '{0, 1, 1, 1, 1, 1, 1, 1, 1, PB, 1};
`else
   localparam lv_t LV_A6 = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1};
   localparam lv_t LV_3C = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
   localparam lv_t LV_00 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
   localparam lv_t LV_FF = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

   logic       x16_BAUD = 1'b0;
   logic       reset    = 1'b1;
   logic [7:0] Di       = 8'h00;
   logic       valid    = 1'b0;
   logic       ready;
   logic       serial_out;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   logic line_a [1:800];
   logic rdy_a  [1:800];
   logic done_a [1:800];

   uart_tx #(
      .P_ODD_PARITY (TB_ODD)
   ) dut (
      .x16_BAUD   (x16_BAUD),
      .reset      (reset),
      .Di         (Di),
      .valid      (valid),
      .ready      (ready),
      .serial_out (serial_out),
      .done       (done)
   );

   always #5 x16_BAUD = ~x16_BAUD;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Wait (bounded) for ready, then present a byte with valid high.
   task automatic launch(input logic [7:0] b);
      int t = 0;
      @(negedge x16_BAUD);
      while (ready !== 1'b1 && t < 1000) begin
         @(negedge x16_BAUD);
         t++;
      end
      check_eq("launch_ready", ready, 1);
      Di    = b;
      valid = 1'b1;
   endtask

   // Record n cycles after the accept edge; optional Di change, valid release and stray pulse.
   task automatic capture(input int n, input int release_at, input logic [7:0] next_di,
                          input int pulse_at, input logic [7:0] pulse_b);
      for (int k = 1; k <= n; k++) begin
         @(negedge x16_BAUD);
         line_a[k] = serial_out;
         rdy_a[k]  = ready;
         done_a[k] = done;
         if (k == 1) Di = next_di;
         if (k == release_at) valid = 1'b0;
         if (k == pulse_at) begin
            valid = 1'b1;
            Di    = pulse_b;
         end
         if (pulse_at > 0 && k == pulse_at + 1) valid = 1'b0;
      end
   endtask

   task automatic check_bits(input string tag, input lv_t lv, input int base);
      for (int i = 0; i < NB; i++) begin
         int bad = 0;
         for (int c = 1; c <= OS; c++) begin
            if (line_a[base + i*OS + c] !== lv[i][0]) bad++;
         end
         check_eq($sformatf("%s_bit%0d", tag, i), bad, 0);
      end
   endtask

   task automatic check_hs(input string tag, input int base);
      int n_done = 0;
      int n_rdy  = 0;
      for (int k = base + 1; k <= base + FRAME; k++) if (done_a[k] === 1'b1) n_done++;
      for (int k = base + 1; k < base + FRAME; k++)  if (rdy_a[k] !== 1'b0) n_rdy++;
      check_eq({tag, "_done_count"}, n_done, 1);
      check_eq({tag, "_done_last"}, done_a[base + FRAME], 1);
      check_eq({tag, "_ready_busy"}, n_rdy, 0);
      check_eq({tag, "_ready_last"}, rdy_a[base + FRAME], 1);
   endtask

   task automatic check_idle_tail(input string tag, input int from, input int to);
      int bad = 0;
      for (int k = from; k <= to; k++) begin
         if (line_a[k] !== 1'b1 || rdy_a[k] !== 1'b1 || done_a[k] !== 1'b0) bad++;
      end
      check_eq(tag, bad, 0);
   endtask

   initial begin
      int bad_line, bad_rdy, bad_done;

      #20;
      check_eq("rst_serial_out", serial_out, 1);
      check_eq("rst_ready", ready, 1);
      check_eq("rst_done", done, 0);
      #30 reset = 1'b0;

      bad_line = 0; bad_rdy = 0; bad_done = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge x16_BAUD);
         if (serial_out !== 1'b1) bad_line++;
         if (ready !== 1'b1) bad_rdy++;
         if (done !== 1'b0) bad_done++;
      end
      check_eq("idle_line", bad_line, 0);
      check_eq("idle_ready", bad_rdy, 0);
      check_eq("idle_done", bad_done, 0);

      // 0xA6, with Di scrambled right after accept.
      launch(8'hA6);
      capture(FRAME + 16, 1, 8'h00, 0, 8'h00);
      check_bits("a6", LV_A6, 0);
      check_hs("a6", 0);
      check_idle_tail("a6_tail", FRAME + 1, FRAME + 16);

      // Stray valid with 0x55 in the middle of the frame.
      launch(8'hA6);
      capture(FRAME + 16, 1, 8'hA6, 40, 8'h55);
      check_bits("ign", LV_A6, 0);
      check_hs("ign", 0);
      check_idle_tail("ign_tail", FRAME + 1, FRAME + 16);

      // Back-to-back 0x00 then 0xFF with valid held across done.
      launch(8'h00);
      capture(2*FRAME + 16, FRAME + 1, 8'hFF, 0, 8'h00);
      check_bits("b2b00", LV_00, 0);
      check_bits("b2bff", LV_FF, FRAME);
      check_hs("b2b00", 0);
      check_hs("b2bff", FRAME);
      check_idle_tail("b2b_tail", 2*FRAME + 1, 2*FRAME + 16);

      // Reset at clock 70 of a frame.
      launch(8'hA6);
      capture(70, 1, 8'hA6, 0, 8'h00);
      check_eq("pre_rst_line", line_a[70], 0);
      #2 reset = 1'b1;
      #1;
      check_eq("midrst_serial_out", serial_out, 1);
      check_eq("midrst_ready", ready, 1);
      check_eq("midrst_done", done, 0);
      @(negedge x16_BAUD);
      reset = 1'b0;
      bad_line = 0; bad_done = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge x16_BAUD);
         if (serial_out !== 1'b1) bad_line++;
         if (done !== 1'b0) bad_done++;
      end
      check_eq("post_rst_line", bad_line, 0);
      check_eq("post_rst_done", bad_done, 0);

      launch(8'h3C);
      capture(FRAME + 16, 1, 8'h00, 0, 8'h00);
      check_bits("3c", LV_3C, 0);
      check_hs("3c", 0);
      check_idle_tail("3c_tail", FRAME + 1, FRAME + 16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
